// File: rtl/dmux_stream_ctrl_if.sv
// dmux_stream_ctrl_if: valid/ready word stream carrying a destination select and payload.
interface dmux_stream_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
);
  logic             valid;
  logic             ready;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] data;
  modport master(output valid, sel, data, input ready);
  modport slave(input valid, sel, data, output ready);
endinterface

// File: rtl/dmux_stream_ctrl.sv
// dmux_stream_ctrl: valid/ready front end, credit tracker and latency-aligned valid generator for the pipelined demux.
module dmux_stream_ctrl #(
  parameter int WIDTH        = 8,
  parameter int OUTPUT_COUNT = 4,
  parameter int LATENCY      = 2,
  parameter int CREDITS      = 4,
  localparam int SEL_W       = $clog2(OUTPUT_COUNT),
  localparam int CW          = $clog2(CREDITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dmux_stream_ctrl_if.slave       s,
  output logic [SEL_W-1:0]        dmux_sel,
  output logic [WIDTH-1:0]        dmux_in,
  output logic [OUTPUT_COUNT-1:0] out_valid,
  input  logic [OUTPUT_COUNT-1:0] credit_return,
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    busy,
  output logic                    err_sel
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0]           credit [OUTPUT_COUNT];
  logic [OUTPUT_COUNT-1:0] pipe [LATENCY+1];
  logic [OUTPUT_COUNT-1:0] has_credit, sel_oh, acc_oh, ret;
  logic legal, acc, reload;
  always_comb begin
    has_credit = '0;
    busy       = 1'b0;
    for (int i = 0; i < OUTPUT_COUNT; i++) has_credit[i] = credit[i] != '0;
    for (int k = 0; k <= LATENCY; k++) busy = busy | (|pipe[k]);
    legal    = 32'(s.sel) < OUTPUT_COUNT;
    sel_oh   = legal ? OUTPUT_COUNT'(1) << s.sel : '0;
    s.ready  = state == RUN && !flush && (!legal || |(sel_oh & has_credit));
    acc      = s.valid && s.ready;
    acc_oh   = acc ? sel_oh : '0;
    ret      = state == DONE ? '0 : credit_return;
    reload   = state == DRAIN && !busy;
    state_nx = state == RUN   ? (flush ? DRAIN : RUN) :
               state == DRAIN ? (busy ? DRAIN : DONE) :
                                (flush ? DONE : RUN);
  end
  assign out_valid  = pipe[LATENCY];
  assign flush_done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      dmux_sel <= '0;
      dmux_in  <= '0;
      err_sel  <= 1'b0;
      for (int k = 0; k <= LATENCY; k++) pipe[k] <= '0;
      for (int i = 0; i < OUTPUT_COUNT; i++) credit[i] <= CW'(CREDITS);
    end else begin
      state    <= state_nx;
      dmux_sel <= acc && legal ? s.sel : dmux_sel;
      dmux_in  <= acc && legal ? s.data : '0;
      err_sel  <= acc && !legal;
      pipe[0]  <= acc_oh;
      for (int k = 1; k <= LATENCY; k++) pipe[k] <= pipe[k-1];
      // simultaneous take and return cancel; returns saturate at full
      for (int i = 0; i < OUTPUT_COUNT; i++)
        if (reload) credit[i] <= CW'(CREDITS);
        else if (acc_oh[i] && !ret[i]) credit[i] <= credit[i] - CW'(1);
        else if (!acc_oh[i] && ret[i] && credit[i] != CW'(CREDITS)) credit[i] <= credit[i] + CW'(1);
    end
  end
endmodule

// File: tb/tb_dmux_stream_ctrl.sv
// tb_dmux_stream_ctrl: table-driven and directed checks of the stream controller in three configurations.
module tb_dmux_stream_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;

  dmux_stream_ctrl_if #(.WIDTH(8), .SEL_W(2)) ia ();
  dmux_stream_ctrl_if #(.WIDTH(8), .SEL_W(2)) ib ();
  dmux_stream_ctrl_if #(.WIDTH(8), .SEL_W(2)) ic ();
  logic [1:0] dsel_a, dsel_b, dsel_c;
  logic [7:0] din_a, din_b, din_c;
  logic [3:0] ov_a, ov_c, cr_a, cr_c;
  logic [2:0] ov_b, cr_b;
  logic fl_a, fl_b, fl_c, fd_a, fd_b, fd_c, bz_a, bz_b, bz_c, er_a, er_b, er_c;

  dmux_stream_ctrl #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(2), .CREDITS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .s(ia), .dmux_sel(dsel_a), .dmux_in(din_a), .out_valid(ov_a),
    .credit_return(cr_a), .flush(fl_a), .flush_done(fd_a), .busy(bz_a), .err_sel(er_a));
  dmux_stream_ctrl #(.WIDTH(8), .OUTPUT_COUNT(3), .LATENCY(2), .CREDITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .s(ib), .dmux_sel(dsel_b), .dmux_in(din_b), .out_valid(ov_b),
    .credit_return(cr_b), .flush(fl_b), .flush_done(fd_b), .busy(bz_b), .err_sel(er_b));
  dmux_stream_ctrl #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(0), .CREDITS(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .s(ic), .dmux_sel(dsel_c), .dmux_in(din_c), .out_valid(ov_c),
    .credit_return(cr_c), .flush(fl_c), .flush_done(fd_c), .busy(bz_c), .err_sel(er_c));

  typedef struct {
    logic v; logic [1:0] sel; logic [7:0] d; logic [3:0] cr;
    logic rdy; logic [1:0] dsel; logic [7:0] din; logic [3:0] ov; logic bz;
  } vec_t;
  vec_t tbl [24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic [1:0] sel, input logic [7:0] d);
    @(negedge clk);
    ia.valid = v; ia.sel = sel; ia.data = d;
    #1;
  endtask

  initial begin
    logic done;
    logic [2:0] ov_or;
    int n_ov;
    tbl = '{
      '{1'b0,2'd0,8'h00,4'h0, 1'b1,2'd0,8'h00,4'h0,1'b0},
      '{1'b1,2'd2,8'hA5,4'h0, 1'b1,2'd0,8'h00,4'h0,1'b0},
      '{1'b0,2'd0,8'h00,4'h0, 1'b1,2'd2,8'hA5,4'h0,1'b1},
      '{1'b0,2'd0,8'h00,4'h0, 1'b1,2'd2,8'h00,4'h0,1'b1},
      '{1'b0,2'd0,8'h00,4'h0, 1'b1,2'd2,8'h00,4'h4,1'b1},
      '{1'b0,2'd0,8'h00,4'h0, 1'b1,2'd2,8'h00,4'h0,1'b0},
      '{1'b1,2'd1,8'h11,4'h0, 1'b1,2'd2,8'h00,4'h0,1'b0},
      '{1'b1,2'd1,8'h12,4'h0, 1'b1,2'd1,8'h11,4'h0,1'b1},
      '{1'b1,2'd1,8'h13,4'h0, 1'b1,2'd1,8'h12,4'h0,1'b1},
      '{1'b1,2'd1,8'h14,4'h0, 1'b1,2'd1,8'h13,4'h2,1'b1},
      '{1'b1,2'd1,8'h15,4'h0, 1'b0,2'd1,8'h14,4'h2,1'b1},
      '{1'b1,2'd1,8'h15,4'h2, 1'b0,2'd1,8'h00,4'h2,1'b1},
      '{1'b1,2'd1,8'h15,4'h2, 1'b1,2'd1,8'h00,4'h2,1'b1},
      '{1'b1,2'd1,8'h16,4'h0, 1'b1,2'd1,8'h15,4'h0,1'b1},
      '{1'b1,2'd1,8'h17,4'h0, 1'b0,2'd1,8'h16,4'h0,1'b1},
      '{1'b0,2'd1,8'h00,4'h0, 1'b0,2'd1,8'h00,4'h2,1'b1},
      '{1'b0,2'd0,8'h00,4'h0, 1'b1,2'd1,8'h00,4'h2,1'b1},
      '{1'b0,2'd0,8'h00,4'h1, 1'b1,2'd1,8'h00,4'h0,1'b0},
      '{1'b1,2'd0,8'h21,4'h0, 1'b1,2'd1,8'h00,4'h0,1'b0},
      '{1'b1,2'd0,8'h22,4'h0, 1'b1,2'd0,8'h21,4'h0,1'b1},
      '{1'b1,2'd0,8'h23,4'h0, 1'b1,2'd0,8'h22,4'h0,1'b1},
      '{1'b1,2'd0,8'h24,4'h0, 1'b1,2'd0,8'h23,4'h1,1'b1},
      '{1'b1,2'd0,8'h25,4'h0, 1'b0,2'd0,8'h24,4'h1,1'b1},
      '{1'b0,2'd0,8'h00,4'h0, 1'b0,2'd0,8'h00,4'h1,1'b1}
    };
    ia.valid = 0; ia.sel = 0; ia.data = 0; cr_a = 0; fl_a = 0;
    ib.valid = 0; ib.sel = 0; ib.data = 0; cr_b = 0; fl_b = 0;
    ic.valid = 0; ic.sel = 0; ic.data = 0; cr_c = 0; fl_c = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // latency alignment, credit exhaustion, return, saturation
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      ia.valid = tbl[k].v; ia.sel = tbl[k].sel; ia.data = tbl[k].d; cr_a = tbl[k].cr;
      #1;
      chk($sformatf("row%0d ready", k), 32'(ia.ready), 32'(tbl[k].rdy));
      chk($sformatf("row%0d dmux_sel", k), 32'(dsel_a), 32'(tbl[k].dsel));
      chk($sformatf("row%0d dmux_in", k), 32'(din_a), 32'(tbl[k].din));
      chk($sformatf("row%0d out_valid", k), 32'(ov_a), 32'(tbl[k].ov));
      chk($sformatf("row%0d busy", k), 32'(bz_a), 32'(tbl[k].bz));
    end
    cr_a = 0;

    // reset with three words in flight
    step_a(1, 2, 8'h41);
    step_a(1, 2, 8'h42);
    step_a(1, 3, 8'h43);
    @(negedge clk);
    ia.valid = 0; ia.sel = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst dmux_sel", 32'(dsel_a), 0);
    chk("rst dmux_in", 32'(din_a), 0);
    chk("rst out_valid", 32'(ov_a), 0);
    chk("rst busy", 32'(bz_a), 0);
    chk("rst err_sel", 32'(er_a), 0);
    chk("rst flush_done", 32'(fd_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step_a(0, 0, 0);
      chk($sformatf("post-rst out_valid c%0d", c), 32'(ov_a), 0);
    end
    for (int c = 0; c < 5; c++) begin
      step_a(1, 0, 8'(8'h50 + c));
      chk($sformatf("post-rst credit0 ready c%0d", c), 32'(ia.ready), c < 4 ? 1 : 0);
    end

    // flush with two words in flight
    repeat (4) step_a(0, 3, 0);
    step_a(1, 3, 8'h31);
    chk("flush pre ready1", 32'(ia.ready), 1);
    step_a(1, 3, 8'h32);
    chk("flush pre ready2", 32'(ia.ready), 1);
    @(negedge clk);
    ia.data = 8'h33; fl_a = 1'b1;
    #1;
    chk("flush ready at once", 32'(ia.ready), 0);
    chk("flush busy", 32'(bz_a), 1);
    done = 1'b0; n_ov = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      #1;
      if (ov_a == 4'b1000) n_ov++;
      done = fd_a;
    end
    chk("flush_done reached", 32'(done), 1);
    chk("flush drained words", n_ov, 2);
    chk("flush busy low", 32'(bz_a), 0);
    chk("flush done ready", 32'(ia.ready), 0);
    @(negedge clk);
    fl_a = 1'b0; ia.valid = 0; ia.sel = 0;
    @(negedge clk);
    #1;
    chk("flush_done cleared", 32'(fd_a), 0);
    for (int c = 0; c < 5; c++) begin
      step_a(1, 0, 8'(8'h60 + c));
      chk($sformatf("flush restore credit0 c%0d", c), 32'(ia.ready), c < 4 ? 1 : 0);
    end
    step_a(0, 0, 0);

    // illegal select on a three-output instance
    @(negedge clk);
    ib.valid = 1; ib.sel = 3; ib.data = 8'h77;
    #1;
    chk("b illegal ready", 32'(ib.ready), 1);
    @(negedge clk);
    ib.valid = 0; ib.sel = 0;
    #1;
    chk("b err_sel pulse", 32'(er_b), 1);
    chk("b dropped dmux_in", 32'(din_b), 0);
    chk("b dmux_sel held", 32'(dsel_b), 0);
    ov_or = 0;
    @(negedge clk);
    #1;
    chk("b err_sel one cycle", 32'(er_b), 0);
    for (int c = 0; c < 4; c++) begin
      ov_or = ov_or | ov_b;
      if (c == 0) chk("b illegal busy", 32'(bz_b), 0);
      @(negedge clk);
      #1;
    end
    chk("b illegal no out_valid", 32'(ov_or), 0);
    for (int i = 0; i < 3; i++) begin
      ib.sel = 2'(i);
      #1;
      chk($sformatf("b credit%0d intact", i), 32'(ib.ready), 1);
    end
    @(negedge clk);
    ib.valid = 1; ib.sel = 2; ib.data = 8'h55;
    @(negedge clk);
    ib.valid = 0;
    #1;
    chk("b legal dmux_in", 32'(din_b), 8'h55);
    chk("b legal dmux_sel", 32'(dsel_b), 2);
    @(negedge clk);
    #1;
    chk("b legal out_valid early", 32'(ov_b), 0);
    @(negedge clk);
    #1;
    chk("b legal out_valid", 32'(ov_b), 3'b100);

    // zero-latency streaming, round robin
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      ic.valid = k < 8; ic.sel = 2'(k % 4); ic.data = 8'(k);
      #1;
      if (k < 8) chk($sformatf("c ready k%0d", k), 32'(ic.ready), 1);
      chk($sformatf("c out_valid k%0d", k), 32'(ov_c), k == 0 ? 0 : 32'(4'b0001 << ((k - 1) % 4)));
    end
    @(negedge clk);
    #1;
    chk("c out_valid idle", 32'(ov_c), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
